// File: rtl/fir_pkg.sv
// Shared types and helpers for the parametrised FIR filter.
//   state_t         : controller states
//   acc_width()     : accumulator width that cannot overflow over all taps
//   sat_occurs()    : true when a value lies outside a signed w-bit range
//   sat_to_width()  : clamp a value to a signed w-bit range
//   mag_clamped()   : magnitude of a signed w-bit value, most-negative
//                     value clamped to the largest positive value
// Helpers work on a SAT_MAX_W-bit carrier so one definition serves any
// width up to SAT_MAX_W-1.
package fir_pkg;

    localparam int SAT_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        MAC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_hi(input int w);
        logic signed [SAT_MAX_W-1:0] one;
        one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_lo(input int w);
        return -sat_hi(w) - {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic sat_occurs(input logic signed [SAT_MAX_W-1:0] v, input int w);
        return (v > sat_hi(w)) || (v < sat_lo(w));
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_to_width(
        input logic signed [SAT_MAX_W-1:0] v, input int w);
        if (v > sat_hi(w)) return sat_hi(w);
        if (v < sat_lo(w)) return sat_lo(w);
        return v;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] mag_clamped(
        input logic signed [SAT_MAX_W-1:0] v, input int w);
        logic signed [SAT_MAX_W-1:0] m;
        m = (v < 0) ? -v : v;
        if (m > sat_hi(w)) m = sat_hi(w);
        return m;
    endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample/coefficient bus between the sample source and the FIR filter.
//   master : drives sample_data, fir_coefficient, load_coeff, data_ready
//            and observes modwait, fir_out, err, one_k_samples
//   slave  : the filter side (directions reversed)
interface fir_filter_param_if #(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 16
) ();
    logic signed [DATA_W-1:0]  sample_data;
    logic signed [COEFF_W-1:0] fir_coefficient;
    logic                      load_coeff;
    logic                      data_ready;
    logic                      modwait;
    logic [DATA_W-1:0]         fir_out;
    logic                      err;
    logic                      one_k_samples;

    modport master (
        output sample_data, fir_coefficient, load_coeff, data_ready,
        input  modwait, fir_out, err, one_k_samples
    );

    modport slave (
        input  sample_data, fir_coefficient, load_coeff, data_ready,
        output modwait, fir_out, err, one_k_samples
    );
endinterface

// File: rtl/fir_sample_counter.sv
// Counts completed filter results and emits a one-cycle pulse every
// CNT_TARGET results.
//   clk, rst     : clock, synchronous active-high reset
//   i_cnt_up     : one-cycle strobe, one result completed
//   o_rollover   : high for the cycle after the CNT_TARGET-th strobe
module fir_sample_counter #(
    parameter int CNT_TARGET = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cnt_up,
    output logic o_rollover
);
    localparam int CNT_W = $clog2(CNT_TARGET + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (i_cnt_up) begin
                if (r_cnt == CNT_W'(CNT_TARGET - 1)) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_rollover = r_pulse;
endmodule

// File: rtl/fir_filter_param.sv
// Parametrised FIR filter built around a single sequential MAC that
// processes one tap per cycle, then saturates the rescaled sum and
// reports its magnitude.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fir_filter_param_if.slave -- sample_data/data_ready,
//              fir_coefficient/load_coeff in; modwait, fir_out, err,
//              one_k_samples out
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int COEFF_W    = 16,
    parameter int NUM_TAPS   = 4,
    parameter int CNT_TARGET = 1000
) (
    input  logic                clk,
    input  logic                rst,
    fir_filter_param_if.slave   bus
);
    localparam int ACC_W  = acc_width(DATA_W, COEFF_W, NUM_TAPS);
    localparam int IDX_W  = $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    state_t                     r_state, w_next;
    logic signed [DATA_W-1:0]   r_x    [NUM_TAPS];
    logic signed [COEFF_W-1:0]  r_coef [NUM_TAPS];
    logic signed [DATA_W-1:0]   r_sample;
    logic signed [COEFF_W-1:0]  r_coef_in;
    logic [IDX_W-1:0]           r_cidx;
    logic [IDX_W-1:0]           r_tap;
    logic signed [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]          r_fir_out;
    logic                       r_err;

    logic                       w_busy;
    logic                       w_drop;
    logic                       w_done;
    logic                       w_rollover;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_shift;
    logic signed [SAT_MAX_W-1:0] w_r_ext;
    logic                       w_sat;

    assign w_busy = (r_state != IDLE);
    assign w_done = (r_state == DONE);

    // A request is lost either because the block is busy, or because a
    // coefficient load and a sample arrive together (the load is kept).
    assign w_drop = (w_busy && (bus.data_ready || bus.load_coeff)) ||
                    (!w_busy && bus.load_coeff && bus.data_ready);

    assign w_prod  = PROD_W'(r_x[r_tap]) * PROD_W'(r_coef[r_tap]);
    // Remove the Q1.(COEFF_W-1) fraction; >>> floors toward -inf.
    assign w_shift = r_acc >>> (COEFF_W - 1);
    assign w_r_ext = SAT_MAX_W'(w_shift);
    assign w_sat   = sat_occurs(w_r_ext, DATA_W);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.load_coeff)      w_next = LOAD;
                else if (bus.data_ready) w_next = SHIFT;
            end
            LOAD:    w_next = IDLE;
            SHIFT:   w_next = MAC;
            MAC:     if (r_tap == LAST_IDX) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_x[k]    <= '0;
                r_coef[k] <= '0;
            end
            r_sample  <= '0;
            r_coef_in <= '0;
            r_cidx    <= '0;
            r_tap     <= '0;
            r_acc     <= '0;
            r_fir_out <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (bus.load_coeff)      r_coef_in <= bus.fir_coefficient;
                else if (bus.data_ready) r_sample  <= bus.sample_data;
            end

            case (r_state)
                LOAD: begin
                    r_coef[r_cidx] <= r_coef_in;
                    r_cidx <= (r_cidx == LAST_IDX) ? '0 : r_cidx + 1'b1;
                end
                SHIFT: begin
                    for (int k = NUM_TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
                    r_x[0] <= r_sample;
                    r_acc  <= '0;
                    r_tap  <= '0;
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_tap <= r_tap + 1'b1;
                end
                DONE: begin
                    r_fir_out <= DATA_W'(mag_clamped(sat_to_width(w_r_ext, DATA_W), DATA_W));
                end
                default: ;
            endcase

            // A drop in the DONE cycle must survive DONE's status update.
            if (w_drop)      r_err <= 1'b1;
            else if (w_done) r_err <= w_sat;
        end
    end

    fir_sample_counter #(
        .CNT_TARGET (CNT_TARGET)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_cnt_up   (w_done),
        .o_rollover (w_rollover)
    );

    assign bus.modwait       = w_busy;
    assign bus.fir_out       = r_fir_out;
    assign bus.err           = r_err;
    assign bus.one_k_samples = w_rollover;
endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: directed scenarios plus randomized traffic
// checked against a plain-arithmetic reference model.
module tb_fir_filter_param;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int NT   = 4;
    localparam int CNTT = 4;
    localparam longint HI = 32767;
    localparam longint LO = -32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_filter_param_if #(.DATA_W(DW), .COEFF_W(CW)) bus ();

    fir_filter_param #(
        .DATA_W(DW), .COEFF_W(CW), .NUM_TAPS(NT), .CNT_TARGET(CNTT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    longint m_coef [NT];
    longint m_x    [NT];
    int     m_cidx;
    int     m_cnt;
    longint m_out;
    longint m_err;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            m_coef[k] = 0;
            m_x[k] = 0;
        end
        m_cidx = 0;
        m_cnt  = 0;
        m_out  = 0;
        m_err  = 0;
    endtask

    // Dot product of history and coefficients, rescaled, saturated, magnitude.
    task automatic model_result(output longint out, output longint sat);
        longint acc, r;
        acc = 0;
        for (int k = 0; k < NT; k++) acc += m_x[k] * m_coef[k];
        r = acc >>> (CW - 1);
        sat = (r > HI || r < LO) ? 1 : 0;
        if (r > HI) r = HI;
        if (r < LO) r = LO;
        out = (r < 0) ? -r : r;
        if (out > HI) out = HI;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_eq("rst_modwait", longint'(bus.modwait), 0);
        check_eq("rst_fir_out", longint'(bus.fir_out), 0);
        check_eq("rst_err", longint'(bus.err), 0);
        check_eq("rst_one_k", longint'(bus.one_k_samples), 0);
    endtask

    task automatic do_load(input longint c, input bit with_sample);
        bus.load_coeff      = 1'b1;
        bus.fir_coefficient = CW'(c);
        bus.data_ready      = with_sample;
        bus.sample_data     = DW'($urandom);
        tick();
        bus.load_coeff = 1'b0;
        bus.data_ready = 1'b0;
        m_coef[m_cidx] = c;
        m_cidx = (m_cidx + 1) % NT;
        if (with_sample) begin
            m_err = 1;
            check_eq("ld_drop_err", longint'(bus.err), 1);
        end
        check_eq("ld_busy", longint'(bus.modwait), 1);
        tick();
        check_eq("ld_idle", longint'(bus.modwait), 0);
        check_eq("ld_err_hold", longint'(bus.err), m_err);
    endtask

    // drop_at: cycle offset (1..6) after acceptance at which an extra
    // data_ready is pulsed; 0 for none.
    task automatic do_sample(input longint s, input int drop_at);
        longint exp_out, exp_sat;
        bus.data_ready  = 1'b1;
        bus.sample_data = DW'(s);
        tick();
        bus.data_ready = 1'b0;
        for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = s;
        check_eq("smp_busy_t1", longint'(bus.modwait), 1);
        check_eq("smp_one_k_low", longint'(bus.one_k_samples), 0);
        for (int t = 1; t < NT + 3; t++) begin
            if (t == drop_at) begin
                bus.data_ready  = 1'b1;
                bus.sample_data = DW'($urandom);
            end
            tick();
            bus.data_ready = 1'b0;
            if (t == drop_at) check_eq("drop_err", longint'(bus.err), 1);
            if (t + 1 < NT + 3) check_eq("smp_busy", longint'(bus.modwait), 1);
        end
        model_result(exp_out, exp_sat);
        m_out = exp_out;
        m_err = (drop_at == NT + 2) ? 1 : exp_sat;
        m_cnt++;
        check_eq("smp_idle", longint'(bus.modwait), 0);
        check_eq("smp_fir_out", longint'(bus.fir_out), m_out);
        check_eq("smp_err", longint'(bus.err), m_err);
        check_eq("smp_one_k", longint'(bus.one_k_samples), (m_cnt == CNTT) ? 1 : 0);
        if (m_cnt == CNTT) m_cnt = 0;
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) tick();
        check_eq("hold_fir_out", longint'(bus.fir_out), m_out);
        check_eq("hold_err", longint'(bus.err), m_err);
    endtask

    initial begin
        longint v;
        int     d;
        bus.sample_data     = '0;
        bus.fir_coefficient = '0;
        bus.load_coeff      = 1'b0;
        bus.data_ready      = 1'b0;
        model_reset();
        tick();
        do_reset();

        // Half-scale coefficients.
        for (int k = 0; k < NT; k++) do_load(16384, 1'b0);
        do_sample(1000, 0);
        check_eq("half_first", longint'(bus.fir_out), 500);
        do_sample(1000, 0);
        check_eq("half_second", longint'(bus.fir_out), 1000);
        idle_hold(3);

        // Positive full scale, then decay with a zero sample.
        for (int k = 0; k < NT; k++) do_load(HI, 1'b0);
        for (int k = 0; k < 4; k++) do_sample(HI, 0);
        check_eq("pos_sat_out", longint'(bus.fir_out), HI);
        check_eq("pos_sat_err", longint'(bus.err), 1);
        do_sample(0, 0);

        // Single tap, negative input.
        do_load(16384, 1'b0);
        for (int k = 1; k < NT; k++) do_load(0, 1'b0);
        do_sample(-20000, 0);
        check_eq("neg_single", longint'(bus.fir_out), 10000);

        // Negative full scale.
        for (int k = 0; k < NT; k++) do_load(HI, 1'b0);
        for (int k = 0; k < 4; k++) do_sample(LO, 0);
        check_eq("neg_sat_out", longint'(bus.fir_out), HI);
        check_eq("neg_sat_err", longint'(bus.err), 1);

        // Requests while busy, including in the final DONE cycle.
        do_sample(1234, 3);
        do_sample(-777, NT + 2);
        do_sample(50, 1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            d = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 1) ? HI : LO;
                default: v = longint'($signed(DW'($urandom)));
            endcase
            if (d < 3) begin
                do_load(v, 1'b0);
            end else begin
                do_sample(v, (d == 9) ? $urandom_range(1, NT + 2) : 0);
            end
        end
        idle_hold(2);

        // Load and sample together.
        do_load(12000, 1'b1);
        idle_hold(1);

        // Reset during MAC.
        for (int k = 0; k < NT; k++) do_load(20000, 1'b0);
        bus.data_ready  = 1'b1;
        bus.sample_data = DW'(9999);
        tick();
        bus.data_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_eq("midmac_modwait", longint'(bus.modwait), 0);
        check_eq("midmac_fir_out", longint'(bus.fir_out), 0);
        check_eq("midmac_err", longint'(bus.err), 0);
        do_sample(30000, 0);
        check_eq("midmac_coef_zero", longint'(bus.fir_out), 0);

        // Counter rollover after a clean reset.
        do_reset();
        for (int k = 0; k < NT; k++) do_load(8192, 1'b0);
        for (int k = 0; k < 9; k++) do_sample(longint'($signed(DW'($urandom))), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
